// File: rtl/kgp_pkg.sv
// kgp_pkg: definitions shared by the KGP-RISC fetch stage and its IF/ID register.
//   fetch_state_t    : fetch FSM state encoding
//   INSTR_W          : instruction width
//   NOP_INSTR        : word that decode treats as a NOP (all control signals zero)
//   RESET_PC_DEFAULT : default first fetch address after reset
package kgp_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// The flush input has priority over load. When neither is asserted, the register holds.
// A flush clears the instruction and the valid flag. It keeps pc and pc4 at their last values.
//   clk, reset_n            : clock and synchronous active-low reset
//   load, flush             : capture a new word / insert a bubble
//   load_instr, load_pc     : word and its address to capture on load
//   if_id_instr/pc/pc4/valid: register contents presented to decode
module if_id_reg
  import kgp_pkg::*;
#(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [31:0]        load_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_instr <= load_instr;
      if_id_pc    <= load_pc;
      if_id_pc4   <= load_pc + PC_STEP;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the KGP-RISC pipeline.
// It holds the PC, drives the imem request handshake, and fills IF/ID.
//
//   state | meaning
//   FETCH | request outstanding at fetch_pc; accepted words go to IF/ID
//   HOLD  | decode stalled, accepted word parked in skid; no request issued
//   DRAIN | wrong-path request still outstanding; redirect_pc waits for it
//
// Ports:
//   clk, reset_n            : clock and synchronous active-low reset
//   stall, pcsrc, target_pc : hazard hold and branch/jump redirect
//   imem_req/addr/ready/rdata : instruction memory handshake
//   if_id_instr/pc/pc4/valid  : IF/ID register outputs
module fetch_stage
  import kgp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               pcsrc,
  input  logic [31:0]        target_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid
);

  fetch_state_t       state;
  logic [31:0]        fetch_pc;
  logic [31:0]        redirect_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;

  logic               id_load;
  logic               id_flush;
  logic [INSTR_W-1:0] id_instr;
  logic [31:0]        id_pc;

  // The request and the address depend only on registered state.
  // This keeps imem_rdata and stall off the address path.
  assign imem_req  = reset_n && (state != HOLD);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      redirect_pc <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (pcsrc) begin
            if (imem_ready) begin
              fetch_pc <= target_pc;
            end else begin
              // The address must stay put until the wrong-path request completes.
              redirect_pc <= target_pc;
              state       <= DRAIN;
            end
          end else if (imem_ready) begin
            fetch_pc <= fetch_pc + PC_STEP;
            if (stall) begin
              skid_instr <= imem_rdata;
              skid_pc    <= fetch_pc;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (pcsrc) begin
            fetch_pc <= target_pc;
            state    <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            fetch_pc <= pcsrc ? target_pc : redirect_pc;
            state    <= FETCH;
          end else if (pcsrc) begin
            redirect_pc <= target_pc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Control for IF/ID. A pcsrc flush always wins, even against stall.
  always_comb begin
    id_load  = 1'b0;
    id_flush = 1'b0;
    id_instr = imem_rdata;
    id_pc    = fetch_pc;
    unique case (state)
      FETCH: begin
        if (pcsrc)           id_flush = 1'b1;
        else if (imem_ready) id_load  = !stall;
        else                 id_flush = !stall;
      end
      HOLD: begin
        id_instr = skid_instr;
        id_pc    = skid_pc;
        if (pcsrc) id_flush = 1'b1;
        else       id_load  = !stall;
      end
      DRAIN:   id_flush = pcsrc || !stall;
      default: id_flush = 1'b1;
    endcase
  end

  if_id_reg #(
    .PC_STEP(PC_STEP)
  ) u_if_id_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (id_load),
    .flush      (id_flush),
    .load_instr (id_instr),
    .load_pc    (id_pc),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// Each test task pushes the addresses it expects decode to receive onto exp_q.
// A monitor pops exp_q whenever a new valid word lands in IF/ID, and checks
// pc, instr and pc4 against the value it popped.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        pcsrc;
  logic [31:0] target_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  logic        stall_at_edge;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  assign imem_rdata = imem_ready ? word(imem_addr) : 32'hBAD0_BAD0;

  fetch_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .target_pc  (target_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A new word can only be loaded at an edge where stall was low.
  // Any valid word seen after such an edge is therefore a fresh arrival.
  always @(posedge clk) stall_at_edge <= stall;

  always @(posedge clk) begin
    #2;
    if (if_id_valid === 1'b1 && stall_at_edge === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc %h instr %h, expected no word", if_id_pc, if_id_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (if_id_pc !== mon_e || if_id_instr !== word(mon_e) || if_id_pc4 !== mon_e + 32'd4) begin
          failures++;
          $display("FAIL sb_word: got pc %h instr %h pc4 %h, expected pc %h instr %h pc4 %h",
                   if_id_pc, if_id_instr, if_id_pc4, mon_e, word(mon_e), mon_e + 32'd4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic check_q_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_sb_left: got %0d pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
    checks++; if ({if_id_instr, if_id_pc, if_id_pc4} !== 96'h0 || if_id_valid !== 1'b0) begin
      failures++; $display("FAIL rst_ifid: got %h %h %h v%b expected all 0", if_id_instr, if_id_pc, if_id_pc4, if_id_valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
        failures++; $display("FAIL stream_addr: got req %b addr %h expected req 1 addr %h", imem_req, imem_addr, 32'(i * 4));
      end
      tick();
      checks++; if (if_id_pc !== 32'(i * 4) || if_id_valid !== 1'b1) begin
        failures++; $display("FAIL stream_pc: got %h v%b expected %h v1", if_id_pc, if_id_valid, 32'(i * 4));
      end
    end
    check_q_empty("stream");
  endtask

  task automatic test_stall_skid();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(32 + i * 4));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_req !== 1'b0 || if_id_pc !== 32'd28 || if_id_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold: got req %b pc %h v%b expected req 0 pc 0000001c v1", imem_req, if_id_pc, if_id_valid);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_id_pc !== 32'd32 || imem_addr !== 32'd36 || imem_req !== 1'b1) begin
      failures++; $display("FAIL stall_release: got pc %h addr %h req %b expected pc 00000020 addr 00000024 req 1", if_id_pc, imem_addr, imem_req);
    end
    repeat (3) tick();
    check_q_empty("stall");
  endtask

  task automatic test_redirect();
    pcsrc = 1'b1; target_pc = 32'h100;
    tick();
    pcsrc = 1'b0; target_pc = 32'hDEAD_BEEC;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'd44 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL redir_bubble: got v%b instr %h pc %h addr %h expected v0 instr 0 pc 0000002c addr 00000100", if_id_valid, if_id_instr, if_id_pc, imem_addr);
    end
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    repeat (2) tick();
    check_q_empty("redir");
  endtask

  task automatic test_redirect_wait();
    imem_ready = 1'b0; pcsrc = 1'b1; target_pc = 32'h40;
    tick();
    pcsrc = 1'b0; target_pc = 32'hBAD0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== 32'h108 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
        failures++; $display("FAIL wait_addr: got addr %h req %b v%b expected addr 00000108 req 1 v0", imem_addr, imem_req, if_id_valid);
      end
      if (i < 2) tick();
    end
    imem_ready = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin
      failures++; $display("FAIL wait_retarget: got addr %h v%b expected addr 00000040 v0", imem_addr, if_id_valid);
    end
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    repeat (2) tick();
    check_q_empty("wait");
  endtask

  task automatic test_flush_beats_stall();
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || if_id_pc !== 32'h44 || if_id_valid !== 1'b1) begin
      failures++; $display("FAIL flush_pre_hold: got req %b pc %h v%b expected req 0 pc 00000044 v1", imem_req, if_id_pc, if_id_valid);
    end
    pcsrc = 1'b1; target_pc = 32'h80;
    tick();
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'h80 || imem_req !== 1'b1) begin
      failures++; $display("FAIL flush_stall: got v%b instr %h addr %h req %b expected v0 instr 0 addr 00000080 req 1", if_id_valid, if_id_instr, imem_addr, imem_req);
    end
    pcsrc = 1'b0; stall = 1'b0;
    exp_q.push_back(32'h80); exp_q.push_back(32'h84);
    repeat (2) tick();
    check_q_empty("flush");
  endtask

  task automatic test_drain_retarget();
    imem_ready = 1'b0; pcsrc = 1'b1; target_pc = 32'h200;
    tick();
    target_pc = 32'h300;
    tick();
    checks++; if (imem_addr !== 32'h88) begin failures++; $display("FAIL drain_stable: got %h expected 00000088", imem_addr); end
    imem_ready = 1'b1; pcsrc = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h300) begin failures++; $display("FAIL drain_overwrite: got %h expected 00000300", imem_addr); end
    imem_ready = 1'b0; pcsrc = 1'b1; target_pc = 32'h500;
    tick();
    imem_ready = 1'b1; target_pc = 32'h400;
    tick();
    checks++; if (imem_addr !== 32'h400 || if_id_valid !== 1'b0) begin
      failures++; $display("FAIL drain_same_cycle: got addr %h v%b expected addr 00000400 v0", imem_addr, if_id_valid);
    end
    pcsrc = 1'b0;
    exp_q.push_back(32'h400);
    tick();
    check_q_empty("drain");
  endtask

  task automatic test_wrap_and_reset();
    pcsrc = 1'b1; target_pc = 32'hFFFF_FFF8;
    tick();
    pcsrc = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    tick();
    checks++; if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL wrap: got pc4 %h addr %h expected 0 0", if_id_pc4, imem_addr);
    end
    repeat (2) tick();
    check_q_empty("wrap");
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b expected 0", imem_req); end
    tick();
    checks++; if ({if_id_instr, if_id_pc, if_id_pc4} !== 96'h0 || if_id_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_ifid: got %h %h %h v%b expected all 0", if_id_instr, if_id_pc, if_id_pc4, if_id_valid);
    end
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL midrst_restart: got req %b addr %h expected req 1 addr 0", imem_req, imem_addr);
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    repeat (2) tick();
    check_q_empty("midrst");
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; pcsrc = 1'b0; target_pc = '0; imem_ready = 1'b1;
    repeat (3) tick();
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect();
    test_redirect_wait();
    test_flush_beats_stall();
    test_drain_retarget();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined KGP-RISC core. It owns the program counter, drives the instruction-memory request handshake, and fills the IF/ID pipeline register that feeds the decode controller. Taken branches and jumps (`pcsrc`, `target_pc`) redirect it, and the hazard unit's `stall` freezes it. Flushed and empty slots present `32'b0`, which decode treats as a NOP with all control signals zero.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `PC_STEP`, default `4`: sequential PC increment (byte addressing).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `stall` in 1: hazard unit holds IF/ID contents.
- `pcsrc` in 1: redirect request from the branch-resolve stage.
- `target_pc` in 32: redirect address, sampled only when `pcsrc`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready` in 1: memory has accepted the request; `imem_rdata` is valid in this same cycle.
- `imem_rdata` in 32: fetched word.
- `if_id_instr` out 32: instruction presented to decode.
- `if_id_pc` out 32: address of `if_id_instr`.
- `if_id_pc4` out 32: `if_id_pc + PC_STEP`.
- `if_id_valid` out 1: `if_id_instr` is a real fetched word.

## Operation
- Registers:
  - `fetch_pc`: address being requested.
  - `redirect_pc`: pending redirect target.
  - `skid_instr` and `skid_pc`: one-entry buffer.
  - `state` ∈ {FETCH, HOLD, DRAIN}.
- `imem_req` = `reset_n` && (`state` != HOLD).
- `imem_addr` = `fetch_pc` in all states.
- FETCH:
  - `pcsrc`=1: discard `imem_rdata` if `imem_ready`=1. If `imem_ready`=1, set `fetch_pc`<=`target_pc` and stay in FETCH. Otherwise set `redirect_pc`<=`target_pc` and go to DRAIN. In both cases IF/ID<=bubble.
  - `imem_ready`=1, `stall`=0: IF/ID<=(`imem_rdata`, `fetch_pc`, valid=1); `fetch_pc`+=`PC_STEP`.
  - `imem_ready`=1, `stall`=1: skid<=(`imem_rdata`, `fetch_pc`); `fetch_pc`+=`PC_STEP`; go to HOLD; IF/ID holds.
  - `imem_ready`=0: IF/ID<=bubble if `stall`=0, otherwise holds.
- HOLD (no request issued):
  - `pcsrc`=1: drop skid; `fetch_pc`<=`target_pc`; IF/ID<=bubble; go to FETCH.
  - `stall`=0: IF/ID<=skid with valid=1; go to FETCH.
  - `stall`=1: remain in HOLD.
- DRAIN (wrong-path request still outstanding; address must not change):
  - Any `imem_ready`=1: discard data; `fetch_pc`<=`redirect_pc`; go to FETCH.
  - A new `pcsrc`=1 overwrites `redirect_pc`. If it arrives in the same cycle as `imem_ready`, `target_pc` is used directly.
  - IF/ID<=bubble each cycle unless `stall`=1.
- Priority: `reset_n` low > `pcsrc` > `stall` > normal flow. `pcsrc` flushes IF/ID even while `stall`=1.
- Bubble = `if_id_instr` 0, `if_id_valid` 0; `if_id_pc` and `if_id_pc4` hold their last values.
- PC arithmetic is modulo 2^32; `32'hFFFF_FFFC` + 4 wraps to 0 silently.

## Timing
- Reset (`reset_n`=0 at an edge):
  - `state`=FETCH; `fetch_pc`=`RESET_PC`.
  - `if_id_instr`, `if_id_pc`, `if_id_pc4` = 0; `if_id_valid`=0.
  - `imem_req`=0 combinationally while `reset_n`=0.
  - Skid and `redirect_pc` = 0.
- Reset asserted mid-request abandons the request. Imem shares `reset_n` and drops the request too.
- First request: the cycle after `reset_n` rises, at `RESET_PC`.
- Latency: word accepted at edge N appears on `if_id_*` after edge N. Zero-wait memory gives one instruction per cycle.
- Redirect: `pcsrc` at edge N. The request for `target_pc` is issued in cycle N+1 if no request is outstanding, otherwise the cycle after the draining `imem_ready`.
- No combinational path from `imem_rdata` or `stall` to `imem_addr`. `imem_req` depends only on registered state and `reset_n`.

## Structure
- Shared package `kgp_pkg`:
  - `fetch_state_t` enum.
  - `NOP_INSTR` = `32'b0`.
  - `RESET_PC_DEFAULT`.
  - `INSTR_W` = 32.
- One natural sub-module: `if_id_reg`, the IF/ID pipeline register with load/flush/hold controls. FSM, PC and skid buffer stay in `fetch_stage`.

## Test plan
- **Reset and zero-wait streaming:** release reset, `imem_ready` tied 1 → `imem_addr` 0, 4, 8…; `if_id_pc` 0, 4, 8 one cycle behind; `if_id_valid`=1 from the second cycle.
- **Stall with skid:** zero-wait stream, `stall`=1 for 3 cycles while the word at 8 is accepted → IF/ID holds pc 4; `imem_req`=0 during HOLD; on release `if_id_pc`=8, then 12.
- **Redirect, no outstanding request:** `pcsrc`=1, `target_pc`=`32'h100` → next IF/ID is bubble (instr 0, valid 0); next request at `32'h100`.
- **Redirect during wait:** `imem_ready` low 3 cycles at address 20, `pcsrc`=1 with `target_pc`=`32'h40` in cycle 1 → `imem_addr` stays 20 until ready; that word is never presented; next request at `32'h40`.
- **Flush beats stall:** `stall`=1 and `pcsrc`=1 together, `target_pc`=`32'h80` → `if_id_valid`=0, instr 0; fetch resumes at `32'h80`.
- **Wrap and mid-run reset:** fetch at `32'hFFFF_FFFC` → next address 0. `reset_n`=0 for one cycle mid-stream → all IF/ID outputs 0; restart at `RESET_PC`.
